turn_sched: RTL and testbench
=============================

TURN_SCHED -- requirements
Module: turn_sched

Interface
REQ-001 SHALL have parameter MAX_PLAYERS, default 4, maximum player count (2..16).
REQ-002 SHALL have parameter RW, default 8, round counter width.
REQ-003 SHALL have localparam PW = clog2(MAX_PLAYERS), player index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-006 SHALL have port start, input, 1, level; loads num_players and begins a game.
REQ-007 SHALL have port num_players, input, PW+1, player count for the next game.
REQ-008 SHALL have port advance, input, 1, level; only its rising edge acts.
REQ-009 SHALL have port elim, input, 1, eliminate player elim_id this cycle.
REQ-010 SHALL have port elim_id, input, PW, index of the player to eliminate.
REQ-011 SHALL have port turn, output, PW, index of the current player.
REQ-012 SHALL have port playing, output, 1, high in state PLAY.
REQ-013 SHALL have port alive, output, MAX_PLAYERS, per-player alive mask.
REQ-014 SHALL have port round_cnt, output, RW, completed rounds.
REQ-015 SHALL have port winner_valid, output, 1, high in state DONE.
REQ-016 SHALL have port winner, output, PW, index of the last alive player; valid when winner_valid=1.
REQ-017 SHALL have port err, output, 1, sticky flag for an illegal num_players at start.

Function
REQ-018 SHALL implement states IDLE, PLAY, DONE; playing=(PLAY), winner_valid=(DONE).
REQ-019 SHALL register advance into adv_q each cycle; adv_rise = advance & ~adv_q; the action takes effect on the same edge that samples the rise.
REQ-020 SHALL, on start in IDLE/DONE with 2<=num_players<=MAX_PLAYERS, set alive to the low num_players bits, turn=0, round_cnt=0, winner=0, err=0, and go to PLAY.
REQ-021 SHALL, on start with illegal num_players, set err=1 and leave the state unchanged; start in PLAY SHALL be ignored.
REQ-022 SHALL, on adv_rise in PLAY, move turn to the next alive index in the current direction, wrapping modulo num_players, in one cycle.
REQ-023 SHALL increment round_cnt when the advance wraps (new turn <= old turn ascending, >= descending), saturating at all-ones.
REQ-024 SHALL, on elim in PLAY with elim_id<num_players and alive[elim_id]=1, clear alive[elim_id]; elim is otherwise ignored.
REQ-025 SHALL, when the eliminated player is turn, move turn as in REQ-022/023 even without adv_rise.
REQ-026 SHALL, on simultaneous elim and adv_rise, apply the elimination first and then take exactly one step from the old turn over the updated mask.
REQ-027 SHALL, when the alive popcount becomes 1, enter DONE with winner = the remaining index on the same edge.
REQ-028 SHALL ignore advance and elim in IDLE and DONE; only start leaves DONE.

Reset
REQ-029 SHALL, on rst=0, set state=IDLE, turn=0, alive=0, round_cnt=0, winner=0, err=0, adv_q=0, dir=0, overriding any simultaneous input, including mid-game.

Configuration
REQ-030 SHALL, when TURN_REVERSE_EN is defined, add input reverse (1, pulse) and output dir (1); reverse in PLAY toggles dir (0 = ascending, 1 = descending), start and reset clear dir, and reverse together with adv_rise uses the new direction.
REQ-031 SHALL, when TURN_REVERSE_EN is undefined, have no reverse/dir ports and advance ascending only.

Verification
REQ-032 SHALL cover: start with num_players=3, then 4 advance rises -> turn 1,2,0,1; round_cnt=1 after the third rise.
REQ-033 SHALL cover: advance held high for 5 cycles -> exactly one step.
REQ-034 SHALL cover: 4 players, turn=1, elim_id=1 with advance rising in the same cycle -> alive=1101, turn=2, a single step.
REQ-035 SHALL cover: eliminate players 0, 2, 3 in sequence from 4 players -> DONE, winner=1, further advance ignored.
REQ-036 SHALL cover: start with num_players=1 or 5 (MAX=4) -> err=1, state IDLE; rst=0 mid-PLAY -> all outputs 0 on the next edge.
REQ-037 SHALL cover, with TURN_REVERSE_EN: 4 players, turn=0, reverse then advance -> turn=3, round_cnt=1.

Source files
------------

// File: rtl/turn_sched.sv
// Turn scheduler: rotates a turn token among alive players, counts rounds and reports the last survivor.
// Optional feature macro: TURN_REVERSE_EN adds a reverse input and a dir output for descending play.
module turn_sched #(
  parameter int MAX_PLAYERS = 4,
  parameter int RW = 8,
  localparam int PW = $clog2(MAX_PLAYERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PW:0]            num_players,
  input  logic                   advance,
  input  logic                   elim,
  input  logic [PW-1:0]          elim_id,
`ifdef TURN_REVERSE_EN
  input  logic                   reverse,
  output logic                   dir,
`endif
  output logic [PW-1:0]          turn,
  output logic                   playing,
  output logic [MAX_PLAYERS-1:0] alive,
  output logic [RW-1:0]          round_cnt,
  output logic                   winner_valid,
  output logic [PW-1:0]          winner,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PW:0] NP_MIN = (PW+1)'(2);
  localparam logic [PW:0] NP_MAX = (PW+1)'(MAX_PLAYERS);

  state_t state, state_n;

  logic                   adv_q;
  logic                   adv_rise;
  logic                   np_legal;
  logic                   start_ok;
  logic                   elim_ok;
  logic                   do_step;
  logic                   wrapped;
  logic                   dir_eff;
  logic                   last_one;
  logic [MAX_PLAYERS-1:0] alive_n;
  logic [MAX_PLAYERS-1:0] start_mask;
  logic [PW-1:0]          turn_step;
  logic [PW-1:0]          last_idx;

`ifdef TURN_REVERSE_EN
  logic dir_q;
  assign dir = dir_q;
`endif

  // Scans every other slot in order and lands on `from` itself last, so a
  // single-bit mask yields that bit's index from any starting point.
  function automatic logic [PW-1:0] next_alive(
    input logic [PW-1:0]          from,
    input logic [MAX_PLAYERS-1:0] mask,
    input logic                   desc
  );
    logic [PW-1:0] res;
    logic          found;
    int            idx;
    res   = from;
    found = 1'b0;
    for (int k = 1; k <= MAX_PLAYERS; k++) begin
      if (desc) begin
        idx = int'(from) - k;
        if (idx < 0) idx = idx + MAX_PLAYERS;
      end else begin
        idx = int'(from) + k;
        if (idx >= MAX_PLAYERS) idx = idx - MAX_PLAYERS;
      end
      if (!found && mask[PW'(idx)]) begin
        found = 1'b1;
        res   = PW'(idx);
      end
    end
    return res;
  endfunction

  always_comb begin
    adv_rise   = advance & ~adv_q;
    np_legal   = (num_players >= NP_MIN) && (num_players <= NP_MAX);
    start_ok   = (state != PLAY) && start && np_legal;
    start_mask = ~({MAX_PLAYERS{1'b1}} << num_players);
`ifdef TURN_REVERSE_EN
    dir_eff = (state == PLAY) ? (dir_q ^ reverse) : dir_q;
`else
    dir_eff = 1'b0;
`endif
    elim_ok = 1'b0;
    if ((state == PLAY) && elim && ({1'b0, elim_id} < NP_MAX))
      elim_ok = alive[elim_id];
    alive_n = alive;
    if (elim_ok)
      alive_n[elim_id] = 1'b0;
    // The step always starts from the old turn but skips over the freshly eliminated slot.
    do_step   = (state == PLAY) && (adv_rise || (elim_ok && (elim_id == turn)));
    turn_step = next_alive(turn, alive_n, dir_eff);
    wrapped   = dir_eff ? (turn_step >= turn) : (turn_step <= turn);
    last_one  = elim_ok && ($countones(alive_n) == 1);
    last_idx  = next_alive('0, alive_n, 1'b0);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start_ok) state_n = PLAY;
      PLAY:       if (last_one) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    playing      = (state == PLAY);
    winner_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      adv_q     <= 1'b0;
      turn      <= '0;
      alive     <= '0;
      round_cnt <= '0;
      winner    <= '0;
      err       <= 1'b0;
`ifdef TURN_REVERSE_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      adv_q <= advance;
      if (state != PLAY) begin
        if (start && np_legal) begin
          alive     <= start_mask;
          turn      <= '0;
          round_cnt <= '0;
          winner    <= '0;
          err       <= 1'b0;
`ifdef TURN_REVERSE_EN
          dir_q     <= 1'b0;
`endif
        end else if (start) begin
          err <= 1'b1;
        end
      end else begin
        alive <= alive_n;
`ifdef TURN_REVERSE_EN
        dir_q <= dir_eff;
`endif
        if (do_step) begin
          turn <= turn_step;
          if (wrapped && (round_cnt != {RW{1'b1}}))
            round_cnt <= round_cnt + 1'b1;
        end
        if (last_one)
          winner <= last_idx;
      end
    end
  end

endmodule

// File: tb/tb_turn_sched.sv
// Scoreboard bench for turn_sched: driver predicts with a game-level model, monitor compares each cycle.
module tb_turn_sched;
  localparam int MP = 4;
  localparam int PW = 2;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW:0]   num_players;
  logic          advance;
  logic          elim;
  logic [PW-1:0] elim_id;
  logic [PW-1:0] turn;
  logic          playing;
  logic [MP-1:0] alive;
  logic [RW-1:0] round_cnt;
  logic          winner_valid;
  logic [PW-1:0] winner;
  logic          err;
`ifdef TURN_REVERSE_EN
  logic          reverse;
  logic          dir;
`endif

  always #5 clk = ~clk;

  turn_sched #(.MAX_PLAYERS(MP), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_players  (num_players),
    .advance      (advance),
    .elim         (elim),
    .elim_id      (elim_id),
`ifdef TURN_REVERSE_EN
    .reverse      (reverse),
    .dir          (dir),
`endif
    .turn         (turn),
    .playing      (playing),
    .alive        (alive),
    .round_cnt    (round_cnt),
    .winner_valid (winner_valid),
    .winner       (winner),
    .err          (err)
  );

  typedef struct packed {
    logic [PW-1:0] turn;
    logic [MP-1:0] alive;
    logic [RW-1:0] round_cnt;
    logic          playing;
    logic          winner_valid;
    logic [PW-1:0] winner;
    logic          err;
    logic          dir;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Game-level reference: mode 0 idle, 1 playing, 2 finished.
  int          m_mode = 0;
  int          m_turn = 0;
  int          m_round = 0;
  int          m_winner = 0;
  int          m_n = 0;
  logic [MP-1:0] m_alive = '0;
  bit          m_err = 0;
  bit          m_prev = 0;
  bit          m_dir = 0;

  function automatic obs_t sample();
    obs_t s;
    s.turn         = turn;
    s.alive        = alive;
    s.round_cnt    = round_cnt;
    s.playing      = playing;
    s.winner_valid = winner_valid;
    s.winner       = winner;
    s.err          = err;
`ifdef TURN_REVERSE_EN
    s.dir          = dir;
`else
    s.dir          = 1'b0;
`endif
    return s;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.turn         = PW'(m_turn);
    o.alive        = m_alive;
    o.round_cnt    = RW'(m_round);
    o.playing      = (m_mode == 1);
    o.winner_valid = (m_mode == 2);
    o.winner       = PW'(m_winner);
    o.err          = m_err;
    o.dir          = m_dir;
    return o;
  endfunction

  task automatic modelStep(input bit r, input bit st, input int n, input bit adv,
                           input bit el, input int id, input bit rv);
    bit rise;
    bit ok;
    int nt;
    if (!r) begin
      m_mode = 0; m_turn = 0; m_round = 0; m_winner = 0;
      m_alive = '0; m_err = 0; m_prev = 0; m_dir = 0;
      return;
    end
    rise   = adv && !m_prev;
    m_prev = adv;
    if (m_mode != 1) begin
      if (st) begin
        if (n >= 2 && n <= MP) begin
          m_mode = 1; m_n = n; m_alive = '0;
          for (int i = 0; i < n; i++) m_alive[PW'(i)] = 1'b1;
          m_turn = 0; m_round = 0; m_winner = 0; m_err = 0; m_dir = 0;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      m_dir = m_dir ^ rv;
      ok = el && (id < m_n) && m_alive[PW'(id)];
      if (ok) m_alive[PW'(id)] = 1'b0;
      if (rise || (ok && id == m_turn)) begin
        nt = m_turn;
        for (int k = 1; k <= m_n; k++) begin
          int c;
          c = m_dir ? (m_turn - k + m_n) % m_n : (m_turn + k) % m_n;
          if (m_alive[PW'(c)]) begin
            nt = c;
            break;
          end
        end
        if (m_dir ? (nt >= m_turn) : (nt <= m_turn))
          if (m_round < (1 << RW) - 1) m_round++;
        m_turn = nt;
      end
      if (ok && $countones(m_alive) == 1) begin
        m_mode = 2;
        for (int i = 0; i < MP; i++)
          if (m_alive[PW'(i)]) m_winner = i;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit st, input int n, input bit adv,
                               input bit el, input int id, input bit rv);
    bit rv_eff;
    rv_eff = rv;
`ifndef TURN_REVERSE_EN
    rv_eff = 1'b0;
`endif
    @(negedge clk);
    rst         = r;
    start       = st;
    num_players = (PW+1)'(n);
    advance     = adv;
    elim        = el;
    elim_id     = PW'(id);
`ifdef TURN_REVERSE_EN
    reverse     = rv_eff;
`endif
    modelStep(r, st, n, adv, el, id, rv_eff);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rise();
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    idle();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("cycle %0d outputs", cyc), 64'(sample()), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; num_players = '0; advance = 1'b0; elim = 1'b0; elim_id = '0;
`ifdef TURN_REVERSE_EN
    reverse = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    doReset();
    checkOutput("reset state", 64'(sample()), 64'(0));

    applyStimulus(1, 1, 3, 0, 0, 0, 0);
    idle();
    rise(); checkOutput("3p first turn", 64'(turn), 64'(1));
    rise(); checkOutput("3p second turn", 64'(turn), 64'(2));
    rise(); checkOutput("3p wrap turn", 64'(turn), 64'(0));
    checkOutput("3p round after wrap", 64'(round_cnt), 64'(1));
    rise(); checkOutput("3p fourth turn", 64'(turn), 64'(1));

    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
    idle();
    checkOutput("held advance single step", 64'(turn), 64'(2));

    doReset();
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    idle();
    rise();
    applyStimulus(1, 0, 0, 1, 1, 1, 0);
    idle();
    checkOutput("elim+adv alive", 64'(alive), 64'(4'b1101));
    checkOutput("elim+adv turn", 64'(turn), 64'(2));

    doReset();
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 0, 1, 3, 0);
    idle();
    checkOutput("winner_valid", 64'(winner_valid), 64'(1));
    checkOutput("winner index", 64'(winner), 64'(1));
    rise();
    checkOutput("done ignores advance", 64'(turn), 64'(1));
    checkOutput("done alive", 64'(alive), 64'(4'b0010));

    doReset();
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    idle();
    checkOutput("err on 1 player", 64'(err), 64'(1));
    checkOutput("idle after bad start", 64'(playing), 64'(0));
    doReset();
    applyStimulus(1, 1, 5, 0, 0, 0, 0);
    idle();
    checkOutput("err on 5 players", 64'(err), 64'(1));
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    idle();
    checkOutput("legal start clears err", 64'(err), 64'(0));
    rise();
    applyStimulus(0, 1, 4, 1, 1, 1, 1);
    idle();
    checkOutput("mid-game reset", 64'(sample()), 64'(0));

`ifdef TURN_REVERSE_EN
    doReset();
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    rise();
    checkOutput("reverse turn", 64'(turn), 64'(3));
    checkOutput("reverse round", 64'(round_cnt), 64'(1));
`endif

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
